// File: rtl/phase_sequencer.sv
// Phase/channel sequencer: steps a phase counter through 0..MAX_COUNT per channel,
// channels through 0..NUM_CHANNELS-1 per frame, in free-run or one-shot frame mode.
module phase_sequencer #(
    parameter int COUNT_WIDTH  = 6,
    parameter int MAX_COUNT    = 63,
    parameter int NUM_CHANNELS = 8,
    parameter int CH_WIDTH     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_enable,
    input  logic                   mode,
    input  logic                   start,
    output logic [COUNT_WIDTH-1:0] current_count,
    output logic [CH_WIDTH-1:0]    current_channel,
    output logic                   phase_0,
    output logic                   phase_last,
    output logic                   busy,
    output logic                   frame_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FREE = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] MAX_C   = COUNT_WIDTH'(MAX_COUNT);
    localparam logic [CH_WIDTH-1:0]    LAST_CH = CH_WIDTH'(NUM_CHANNELS - 1);

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [CH_WIDTH-1:0]    channel_q, channel_d;
    logic                   frame_done_q, frame_done_d;

    logic                   active_s;
    logic                   advance_s;
    logic                   count_end_s;
    logic                   chan_end_s;
    logic                   chan_valid_s;
    logic                   frame_wrap_s;
    logic [COUNT_WIDTH-1:0] count_next_s;
    logic [CH_WIDTH-1:0]    channel_next_s;

    assign active_s     = (state_q == RUN) || (state_q == FREE);
    assign advance_s    = active_s && clk_enable;
    // Using >= lets an out-of-range counter fall back to zero on the next advance.
    assign count_end_s  = (count_q >= MAX_C);
    assign chan_end_s   = (channel_q >= LAST_CH);
    assign chan_valid_s = (channel_q <= LAST_CH);
    assign frame_wrap_s = advance_s && count_end_s && chan_end_s;

    // Next phase/channel values for an enabled advance.
    always_comb begin
        count_next_s   = count_q;
        channel_next_s = channel_q;
        if (count_end_s) begin
            count_next_s = '0;
            if (chan_end_s) begin
                channel_next_s = '0;
            end else begin
                channel_next_s = channel_q + CH_WIDTH'(1);
            end
        end else begin
            count_next_s = count_q + COUNT_WIDTH'(1);
            if (chan_valid_s) begin
                channel_next_s = channel_q;
            end else begin
                channel_next_s = '0;
            end
        end
    end

    // FSM next-state and next-output decode.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        channel_d    = channel_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                count_d   = '0;
                channel_d = '0;
                if (!mode) begin
                    state_d = FREE;
                end else if (start) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (frame_wrap_s) begin
                    state_d      = IDLE;
                    count_d      = '0;
                    channel_d    = '0;
                    frame_done_d = 1'b1;
                end else if (advance_s) begin
                    count_d   = count_next_s;
                    channel_d = channel_next_s;
                end else begin
                    count_d   = count_q;
                    channel_d = channel_q;
                end
            end
            FREE: begin
                frame_done_d = frame_wrap_s;
                if (mode) begin
                    state_d   = IDLE;
                    count_d   = '0;
                    channel_d = '0;
                end else if (advance_s) begin
                    count_d   = count_next_s;
                    channel_d = channel_next_s;
                end else begin
                    count_d   = count_q;
                    channel_d = channel_q;
                end
            end
            default: begin
                state_d   = IDLE;
                count_d   = '0;
                channel_d = '0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any frame without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            channel_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            channel_q    <= channel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign current_count   = count_q;
    assign current_channel = channel_q;
    assign frame_done      = frame_done_q;
    assign busy            = active_s;
    assign phase_0         = advance_s && (count_q == '0);
    assign phase_last      = advance_s && (count_q == MAX_C);

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: default build (63/8) plus a small 5/1 build.
module tb_phase_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clk_enable, mode, start;
    logic [5:0] current_count;
    logic [2:0] current_channel;
    logic       phase_0, phase_last, busy, frame_done;

    logic       s_rst, s_en, s_mode, s_start;
    logic [2:0] s_count;
    logic [0:0] s_channel;
    logic       s_p0, s_pl, s_busy, s_fd;

    phase_sequencer dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .mode(mode), .start(start),
        .current_count(current_count), .current_channel(current_channel),
        .phase_0(phase_0), .phase_last(phase_last), .busy(busy), .frame_done(frame_done)
    );

    phase_sequencer #(.COUNT_WIDTH(3), .MAX_COUNT(5), .NUM_CHANNELS(1), .CH_WIDTH(1)) dut_s (
        .clk(clk), .rst(s_rst), .clk_enable(s_en), .mode(s_mode), .start(s_start),
        .current_count(s_count), .current_channel(s_channel),
        .phase_0(s_p0), .phase_last(s_pl), .busy(s_busy), .frame_done(s_fd)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;
    int   exp_ch   = 0;
    logic fd_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_outputs(input string tag, input int cnt, input int ch,
                                  input logic bsy, input logic fd);
        check({tag, "/count"},      32'(current_count),   32'(cnt));
        check({tag, "/channel"},    32'(current_channel), 32'(ch));
        check({tag, "/busy"},       32'(busy),            32'(bsy));
        check({tag, "/frame_done"}, 32'(frame_done),      32'(fd));
    endtask

    // Reference for the default build: 64 phases x 8 channels per frame.
    task automatic model_advance(output logic wrap);
        wrap = (exp_cnt == 63) && (exp_ch == 7);
        if (exp_cnt >= 63) begin
            exp_cnt = 0;
            exp_ch  = (exp_ch == 7) ? 0 : exp_ch + 1;
        end else begin
            exp_cnt = exp_cnt + 1;
        end
    endtask

    initial begin
        rst = 1'b1; clk_enable = 1'b1; mode = 1'b0; start = 1'b0;
        s_rst = 1'b1; s_en = 1'b1; s_mode = 1'b0; s_start = 1'b0;
        repeat (3) tick();
        expect_outputs("reset", 0, 0, 1'b0, 1'b0);
        check("reset/phase_0", 32'(phase_0), 32'(0));
        check("reset/phase_last", 32'(phase_last), 32'(0));

        mode = 1'b1; start = 1'b1; clk_enable = 1'b0;
        tick();
        expect_outputs("reset_held", 0, 0, 1'b0, 1'b0);
        mode = 1'b0; start = 1'b0; clk_enable = 1'b1;

        // Free-run: entry edge does not advance the counter.
        rst = 1'b0;
        tick();
        expect_outputs("free_entry", 0, 0, 1'b1, 1'b0);
        check("free_entry/phase_0", 32'(phase_0), 32'(1));
        exp_cnt = 0; exp_ch = 0;
        for (int k = 1; k <= 1172; k++) begin
            tick();
            model_advance(fd_exp);
            expect_outputs("free_run", exp_cnt, exp_ch, 1'b1, fd_exp);
            if (exp_cnt == 63) check("free_run/phase_last", 32'(phase_last), 32'(1));
        end
        check("free_at_20_2", 32'(current_count * 8 + current_channel), 32'(20 * 8 + 2));

        mode = 1'b1;
        tick();
        expect_outputs("free_exit", 0, 0, 1'b0, 1'b0);
        check("idle/phase_0", 32'(phase_0), 32'(0));
        tick();
        expect_outputs("idle_hold", 0, 0, 1'b0, 1'b0);

        // One-shot frame with stray start and mode toggles that RUN must ignore.
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_outputs("run_entry", 0, 0, 1'b1, 1'b0);
        exp_cnt = 0; exp_ch = 0;
        for (int k = 1; k <= 512; k++) begin
            start = (k == 100);
            mode  = (k != 200);
            tick();
            model_advance(fd_exp);
            if (k < 512) begin
                expect_outputs("oneshot", exp_cnt, exp_ch, 1'b1, 1'b0);
            end else begin
                expect_outputs("oneshot_done", 0, 0, 1'b0, 1'b1);
            end
        end
        tick();
        expect_outputs("oneshot_idle", 0, 0, 1'b0, 1'b0);

        // Enable 1-of-3 in RUN.
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_outputs("run_entry2", 0, 0, 1'b1, 1'b0);
        exp_cnt = 0; exp_ch = 0;
        for (int i = 0; i < 30; i++) begin
            clk_enable = (i % 3 == 0);
            #1;
            check("en_gate/phase_0", 32'(phase_0), 32'((exp_cnt == 0) && clk_enable));
            tick();
            if (clk_enable) model_advance(fd_exp);
            expect_outputs("en_gate", exp_cnt, exp_ch, 1'b1, 1'b0);
        end
        clk_enable = 1'b1;
        for (int g = 0; g < 600 && !(exp_cnt == 37 && exp_ch == 5); g++) begin
            tick();
            model_advance(fd_exp);
            expect_outputs("run_to_37", exp_cnt, exp_ch, 1'b1, 1'b0);
        end

        // Asynchronous reset between edges at count 37 / channel 5.
        #3;
        rst = 1'b1;
        #1;
        expect_outputs("async_rst", 0, 0, 1'b0, 1'b0);
        tick();
        expect_outputs("async_rst_edge", 0, 0, 1'b0, 1'b0);
        mode = 1'b1; start = 1'b1; rst = 1'b0;
        tick();
        expect_outputs("restart", 0, 0, 1'b1, 1'b0);

        // start held high: frames back-to-back with one IDLE cycle between.
        exp_cnt = 0; exp_ch = 0;
        for (int k = 1; k <= 512; k++) begin
            tick();
            model_advance(fd_exp);
            if (k < 512) begin
                expect_outputs("b2b", exp_cnt, exp_ch, 1'b1, 1'b0);
            end else begin
                expect_outputs("b2b_done", 0, 0, 1'b0, 1'b1);
            end
        end
        tick();
        expect_outputs("b2b_rerun", 0, 0, 1'b1, 1'b0);
        start = 1'b0;

        // Small build: 6 phases, single channel.
        s_rst = 1'b0;
        tick();
        check("small_entry/busy", 32'(s_busy), 32'(1));
        check("small_entry/count", 32'(s_count), 32'(0));
        for (int k = 1; k <= 18; k++) begin
            tick();
            check("small/count", 32'(s_count), 32'(k % 6));
            check("small/channel", 32'(s_channel), 32'(0));
            check("small/frame_done", 32'(s_fd), 32'(k % 6 == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter COUNT_WIDTH, default 6: width of the phase counter.
REQ-002 Parameter MAX_COUNT, default 63: terminal phase value; 1 <= MAX_COUNT <= 2^COUNT_WIDTH-1.
REQ-003 Parameter NUM_CHANNELS, default 8: number of channels (bands) per frame; >= 1.
REQ-004 Parameter CH_WIDTH, default 3: channel index width; 2^CH_WIDTH >= NUM_CHANNELS.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 clk_enable  input  1  phase advance qualifier.
REQ-008 mode  input  1  0 = free-run, 1 = one-shot frame.
REQ-009 start  input  1  one-shot frame request, level-sampled in IDLE.
REQ-010 current_count  output  COUNT_WIDTH  registered phase index.
REQ-011 current_channel  output  CH_WIDTH  registered channel index.
REQ-012 phase_0  output  1  combinational: active && current_count==0 && clk_enable.
REQ-013 phase_last  output  1  combinational: active && current_count==MAX_COUNT && clk_enable.
REQ-014 busy  output  1  combinational: state is RUN or FREE ("active").
REQ-015 frame_done  output  1  registered one-cycle pulse at frame completion.

Function
REQ-016 FSM states IDLE, RUN, FREE; state register only, no other hidden state.
REQ-017 IDLE: count and channel held at 0; mode==0 -> FREE next edge; mode==1 && start==1 -> RUN next edge; otherwise stay.
REQ-018 IDLE->RUN / IDLE->FREE transition edge does not advance count; first advance is the next edge with clk_enable==1.
REQ-019 RUN/FREE advance (clk_enable==1 only): count<MAX_COUNT -> count+1; count>=MAX_COUNT -> count=0 and channel advances.
REQ-020 Channel advance: channel<NUM_CHANNELS-1 -> channel+1; else channel=0 (frame wrap); NUM_CHANNELS==1 keeps channel at 0.
REQ-021 clk_enable==0: count, channel and state hold (except REQ-023 mode exit).
REQ-022 Frame wrap (count==MAX_COUNT, channel==NUM_CHANNELS-1, clk_enable==1) sets frame_done=1 on that edge; frame_done=0 on every other edge.
REQ-023 FREE: mode==1 sampled on any edge -> IDLE next edge, count/channel cleared to 0, no frame_done unless the same edge is a frame wrap.
REQ-024 RUN: mode and start ignored; on frame wrap -> IDLE (count/channel 0); no re-trigger until back in IDLE.
REQ-025 IDLE with start held high in mode 1: frames run back-to-back with exactly one IDLE cycle between them.
REQ-026 Counters are unsigned, wrap only per REQ-019/020; any out-of-range value (count>MAX_COUNT or channel>=NUM_CHANNELS) resolves to 0 on next advance.
REQ-027 phase_0, phase_last, busy are 0 in IDLE regardless of clk_enable.

Reset
REQ-028 rst==1 forces immediately (asynchronously): state=IDLE, current_count=0, current_channel=0, frame_done=0.
REQ-029 Reset mid-frame (RUN or FREE) aborts the frame with no frame_done; operation resumes per REQ-017 after rst deasserts.
REQ-030 With rst held, outputs remain at reset values irrespective of clk, clk_enable, mode, start.

Verification
REQ-031 Defaults, mode=0, clk_enable=1 constant after reset -> count 0..63 repeats, channel increments at each wrap, frame_done pulses once every 512 enabled cycles (count=63, channel=7 edge).
REQ-032 mode=1, start pulsed 1 cycle, clk_enable=1 -> busy high for 512 cycles, frame_done one pulse, then IDLE with count=0, channel=0, busy=0.
REQ-033 clk_enable toggling 1-of-3 cycles in RUN -> count advances only on enabled edges; phase_0 high only when count==0 and clk_enable==1.
REQ-034 rst asserted asynchronously (between edges) at count=37, channel=5 in RUN -> outputs 0 immediately, no frame_done; start afterwards begins a fresh frame at 0/0.
REQ-035 FREE at count=20 channel=2, mode driven to 1 -> next edge IDLE, count=0, channel=0, busy=0; start in RUN ignored mid-frame.
REQ-036 Parameters MAX_COUNT=5, NUM_CHANNELS=1, COUNT_WIDTH=3, CH_WIDTH=1 -> count 0..5 wrap, channel stuck 0, frame_done every 6 enabled cycles.
